float_byte_bridge: RTL and testbench
====================================

Name: float_byte_bridge

Overview:
- Byte-stream front end for the float datapath.
- Assembles four received bytes into a 32-bit float word and drives it onto the datapath input (io_float_input_value).
- After a fixed latency, captures the datapath result (io_float_output_value) and returns it as four transmitted bytes.
- Sits between the Caravel-side byte I/O and the Testbench/float core; it is the producer of the core's input and the consumer of its output.

Parameters:
- RESULT_LATENCY, 1, cycles to wait after driving a new word before sampling io_float_output_value (legal range 0..15).
- COUNT_W, 16, width of the completed-word counter.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous abort of the current word.
- rx_byte  input  8  received byte.
- rx_valid  input  1  rx_byte valid.
- rx_ready  output  1  bridge accepts rx_byte.
- tx_byte  output  8  transmitted byte.
- tx_valid  output  1  tx_byte valid.
- tx_ready  input  1  sink accepts tx_byte.
- io_float_input_value  output  32  word driven to the float core.
- io_float_output_value  input  32  result from the float core.
- busy  output  1  high in any state other than RECV.
- words_done  output  COUNT_W  number of completed words; wraps modulo 2^COUNT_W.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low; ports are named clock and reset.
- Reset values (while reset=0):
  - state=IDLE; rx_ready=0, tx_valid=0, tx_byte=0.
  - io_float_input_value=0, words_done=0, byte index=0, busy=1.
- FSM states: IDLE, RECV, WAIT, SEND.
  - IDLE: exactly one cycle after reset release, then RECV unconditionally.
  - RECV: rx_ready=1. A byte transfers on rx_valid&&rx_ready at the clock edge. Byte order is little-endian: the 1st byte fills bits [7:0], the 4th fills [31:24]. On the 4th transfer, the assembled word loads into io_float_input_value, the latency counter loads RESULT_LATENCY, and the FSM goes to WAIT.
  - WAIT: rx_ready=0. The counter decrements each cycle. When the counter is 0, io_float_output_value is sampled into the tx shift register, the byte index clears, and the FSM goes to SEND.
    - With RESULT_LATENCY=0, the sample occurs on the first WAIT cycle.
  - SEND: tx_valid=1 and tx_byte = bits [7:0] of the shift register. On tx_valid&&tx_ready, the register shifts right by 8. After the 4th transfer: words_done increments, tx_valid drops, and the FSM goes to RECV.
  - tx_byte and tx_valid must hold stable while tx_ready=0.
- Timing (last rx byte accepted at edge E):
  - io_float_input_value updates at E.
  - Sample occurs at edge E+1+RESULT_LATENCY.
  - tx_valid first high in the cycle after that edge.
  - Minimum round trip with RESULT_LATENCY=1: the first tx byte is valid 2 cycles after the last rx byte.
- io_float_input_value holds its last loaded word until the next 4th byte or reset. It does not change during partial reception.
- rx_valid is ignored outside RECV. tx_ready is ignored outside SEND.
- flush (synchronous; priority over all other transitions, below reset):
  - Next state RECV, byte index 0, partial rx bytes and pending tx bytes discarded, tx_valid=0 next cycle.
  - io_float_input_value and words_done are unchanged.
  - flush during the 4th rx transfer: the transfer is discarded and no load occurs.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). No partial word survives.
- words_done wraps from 2^COUNT_W-1 to 0.

Decomposition:
- Shared package float_bridge_pkg:
  - state enum (IDLE, RECV, WAIT, SEND).
  - BYTES_PER_WORD=4.
  - FLOAT_W=32.
- No sub-module. The rx packer and tx shifter are each a few registers, so the block stays flat (about 150–200 lines).

Test Plan:
- Loopback with an identity core (output = input), RESULT_LATENCY=1: send rx bytes 00,00,80,3F -> io_float_input_value=0x3F800000; tx emits 00,00,80,3F; words_done=1; first tx_valid 2 cycles after the last rx accept.
- Backpressure: tx_ready held 0 for 5 cycles on byte 2 of result 0xC0490FDB -> tx_byte stays 0x0F with tx_valid=1; the sequence completes DB,0F,49,C0; rx_ready=0 throughout SEND.
- rx gaps: bytes 0x11,0x22,0x33,0x44 with 3 idle cycles between each -> io_float_input_value stays at its old value until the 4th byte, then becomes 0x44332211.
- flush after 2 rx bytes, then full word AA,BB,CC,DD -> io_float_input_value=0xDDCCBBAA; words_done increments by exactly 1.
- Reset (reset=0) asserted during SEND after 1 tx byte -> tx_valid=0 and io_float_input_value=0 immediately; after release, one IDLE cycle then rx_ready=1.
- COUNT_W=2: complete 5 words -> words_done sequence 1,2,3,0,1; with RESULT_LATENCY=0, tx_valid is first high 1 cycle after the last rx accept.

Source files
------------

// File: rtl/float_bridge_pkg.sv
// Shared types and constants for the byte-stream front end of the float datapath.
package float_bridge_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned FLOAT_W        = 32;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWait,
    StSend
  } state_e;

endpackage

// File: rtl/float_byte_bridge.sv
// Packs four little-endian rx bytes into a float word for the core, waits a fixed latency,
// then returns the core result as four tx bytes.
module float_byte_bridge
  import float_bridge_pkg::*;
#(
  parameter int unsigned RESULT_LATENCY = 1,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [BYTE_W-1:0]  rx_byte,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [BYTE_W-1:0]  tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [FLOAT_W-1:0] io_float_input_value,
  input  logic [FLOAT_W-1:0] io_float_output_value,
  output logic               busy,
  output logic [COUNT_W-1:0] words_done
);

  localparam int unsigned IdxW  = $clog2(BYTES_PER_WORD);
  localparam int unsigned LatW  = 4;
  localparam int unsigned AccW  = FLOAT_W - BYTE_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [AccW-1:0]     rx_acc_q, rx_acc_d;
  logic [FLOAT_W-1:0]  in_val_q, in_val_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [FLOAT_W-1:0]  tx_sh_q, tx_sh_d;
  logic [COUNT_W-1:0]  words_q, words_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rx_acc_d = rx_acc_q;
    in_val_d = in_val_q;
    lat_d    = lat_q;
    tx_sh_d  = tx_sh_q;
    words_d  = words_q;

    unique case (state_q)
      StIdle: state_d = StRecv;
      StRecv: begin
        if (rx_valid) begin
          if (idx_q == LastIdx) begin
            in_val_d = {rx_byte, rx_acc_q};
            lat_d    = LatW'(RESULT_LATENCY);
            idx_d    = '0;
            state_d  = StWait;
          end else begin
            // Earlier bytes shift down so the first byte ends up in the low lane.
            rx_acc_d = {rx_byte, rx_acc_q[AccW-1:BYTE_W]};
            idx_d    = idx_q + IdxW'(1);
          end
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          tx_sh_d = io_float_output_value;
          idx_d   = '0;
          state_d = StSend;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      StSend: begin
        if (tx_ready) begin
          tx_sh_d = tx_sh_q >> BYTE_W;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            words_d = words_q + COUNT_W'(1);
            state_d = StRecv;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any transfer in flight; the loaded word and count are kept.
    if (flush) begin
      state_d  = StRecv;
      idx_d    = '0;
      rx_acc_d = rx_acc_q;
      in_val_d = in_val_q;
      lat_d    = lat_q;
      tx_sh_d  = '0;
      words_d  = words_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rx_acc_q <= '0;
      in_val_q <= '0;
      lat_q    <= '0;
      tx_sh_q  <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rx_acc_q <= rx_acc_d;
      in_val_q <= in_val_d;
      lat_q    <= lat_d;
      tx_sh_q  <= tx_sh_d;
      words_q  <= words_d;
    end
  end

  always_comb begin
    rx_ready             = (state_q == StRecv);
    tx_valid             = (state_q == StSend);
    tx_byte              = tx_valid ? tx_sh_q[BYTE_W-1:0] : '0;
    busy                 = (state_q != StRecv);
    io_float_input_value = in_val_q;
    words_done           = words_q;
  end

endmodule

// File: tb/tb_float_byte_bridge.sv
// Bench for float_byte_bridge: two instances (latency 1 / 16-bit count, latency 0 / 2-bit count)
// checked against a byte-level model of the word round trip.
module tb_float_byte_bridge;

  localparam int unsigned LatA = 1;
  localparam int unsigned LatB = 0;
  localparam int unsigned CwA  = 16;
  localparam int unsigned CwB  = 2;

  logic        clock = 1'b0;
  logic        reset    [2];
  logic        flush    [2];
  logic [7:0]  rx_byte  [2];
  logic        rx_valid [2];
  logic        rx_ready [2];
  logic [7:0]  tx_byte  [2];
  logic        tx_valid [2];
  logic        tx_ready [2];
  logic [31:0] fin      [2];
  logic [31:0] fout     [2];
  logic        busy     [2];
  logic [CwA-1:0] done_a;
  logic [CwB-1:0] done_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_in   [2];
  int unsigned m_done [2];

  always #5 clock = ~clock;

  // Core models: identity on A, fixed xor on B.
  assign fout[0] = fin[0];
  assign fout[1] = fin[1] ^ 32'h5A5A_0FF0;

  float_byte_bridge #(.RESULT_LATENCY(LatA), .COUNT_W(CwA)) u_dut_a (
    .clock(clock), .reset(reset[0]), .flush(flush[0]),
    .rx_byte(rx_byte[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .io_float_input_value(fin[0]), .io_float_output_value(fout[0]),
    .busy(busy[0]), .words_done(done_a)
  );

  float_byte_bridge #(.RESULT_LATENCY(LatB), .COUNT_W(CwB)) u_dut_b (
    .clock(clock), .reset(reset[1]), .flush(flush[1]),
    .rx_byte(rx_byte[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .io_float_input_value(fin[1]), .io_float_output_value(fout[1]),
    .busy(busy[1]), .words_done(done_b)
  );

  function automatic logic [31:0] core(int s, logic [31:0] w);
    return (s == 0) ? w : (w ^ 32'h5A5A_0FF0);
  endfunction

  function automatic logic [7:0] byte_of(logic [31:0] w, int i);
    return 8'((w / (32'd1 << (8 * i))) % 256);
  endfunction

  function automatic logic [31:0] done_of(int s);
    return (s == 0) ? 32'(done_a) : 32'(done_b);
  endfunction

  function automatic int unsigned mod_of(int s);
    return (s == 0) ? (32'd1 << CwA) : (32'd1 << CwB);
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? int'(LatA) : int'(LatB);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic send_byte(int s, logic [7:0] b);
    int n;
    n = 0;
    rx_valid[s] = 1'b1;
    rx_byte[s]  = b;
    while (!rx_ready[s] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rx_ready_timeout", 32'(n < 50), 32'd1);
    @(posedge clock);
    @(negedge clock);
    rx_valid[s] = 1'b0;
  endtask

  task automatic rx_word(int s, logic [31:0] w, int gap);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) @(negedge clock);
      send_byte(s, byte_of(w, i));
      if (i < 3) chk("in_hold_partial", fin[s], m_in[s]);
    end
    m_in[s] = w;
    chk("in_load", fin[s], w);
  endtask

  task automatic wait_tx(int s, output int n);
    n = 0;
    while (!tx_valid[s] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("tx_valid_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic tx_word(int s, logic [31:0] res, int exp_wait, int stall_i, int stall_n);
    for (int i = 0; i < 4; i++) begin
      int n;
      wait_tx(s, n);
      if (i == 0 && exp_wait >= 0) chk("first_tx_latency", 32'(n), 32'(exp_wait));
      if (i == stall_i) begin
        repeat (stall_n) begin
          chk("stall_tx_byte", 32'(tx_byte[s]), 32'(byte_of(res, i)));
          chk("stall_tx_valid", 32'(tx_valid[s]), 32'd1);
          @(negedge clock);
        end
      end
      chk("tx_byte", 32'(tx_byte[s]), 32'(byte_of(res, i)));
      chk("rx_ready_in_send", 32'(rx_ready[s]), 32'd0);
      tx_ready[s] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      tx_ready[s] = 1'b0;
    end
    m_done[s] = (m_done[s] + 1) % mod_of(s);
    chk("words_done", done_of(s), m_done[s]);
    chk("tx_valid_after_word", 32'(tx_valid[s]), 32'd0);
    chk("rx_ready_after_word", 32'(rx_ready[s]), 32'd1);
  endtask

  task automatic round(int s, logic [31:0] w, int gap, int stall_i, int stall_n);
    rx_word(s, w, gap);
    tx_word(s, core(s, w), lat_of(s) + 1, stall_i, stall_n);
  endtask

  task automatic chk_reset_vals(int s);
    chk("rst_rx_ready", 32'(rx_ready[s]), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid[s]), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte[s]), 32'd0);
    chk("rst_input_value", fin[s], 32'd0);
    chk("rst_busy", 32'(busy[s]), 32'd1);
    chk("rst_words_done", done_of(s), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] w;
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b0; flush[s] = 1'b0; rx_valid[s] = 1'b0; rx_byte[s] = 8'h00;
      tx_ready[s] = 1'b0; m_in[s] = 32'd0; m_done[s] = 0;
    end
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(negedge clock);
    @(negedge clock);
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    #1;
    chk("idle_rx_ready", 32'(rx_ready[0]), 32'd0);
    @(negedge clock);
    chk("recv_rx_ready_a", 32'(rx_ready[0]), 32'd1);
    chk("recv_rx_ready_b", 32'(rx_ready[1]), 32'd1);
    chk("recv_busy", 32'(busy[0]), 32'd0);

    // Loopback, backpressure on the second byte, and rx gaps.
    round(0, 32'h3F80_0000, 0, -1, 0);
    round(0, 32'hC049_0FDB, 0, 1, 5);
    round(0, 32'h4433_2211, 3, -1, 0);

    // Flush after two bytes, then flush coinciding with the fourth byte.
    send_byte(0, 8'h55);
    send_byte(0, 8'h66);
    flush[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush[0] = 1'b0;
    chk("flush_partial_hold", fin[0], m_in[0]);
    chk("flush_partial_ready", 32'(rx_ready[0]), 32'd1);
    for (int i = 0; i < 3; i++) send_byte(0, 8'h70 + 8'(i));
    flush[0] = 1'b1;
    send_byte(0, 8'h73);
    flush[0] = 1'b0;
    chk("flush_4th_no_load", fin[0], m_in[0]);
    chk("flush_4th_stay_recv", 32'(rx_ready[0]), 32'd1);
    round(0, 32'hDDCC_BBAA, 0, -1, 0);

    // Flush while a result is pending on tx.
    rx_word(0, 32'h1234_5678, 0);
    wait_tx(0, n);
    flush[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush[0] = 1'b0;
    chk("flush_send_tx_valid", 32'(tx_valid[0]), 32'd0);
    chk("flush_send_done", done_of(0), m_done[0]);
    chk("flush_send_input", fin[0], m_in[0]);
    round(0, 32'h0BAD_F00D, 1, 3, 2);

    repeat (20) begin
      w = $urandom;
      round(0, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
            int'($urandom_range(1, 4)));
    end

    // Asynchronous reset during SEND after one byte.
    rx_word(0, 32'hCAFE_BABE, 0);
    wait_tx(0, n);
    tx_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tx_ready[0] = 1'b0;
    reset[0] = 1'b0;
    #1;
    chk_reset_vals(0);
    m_in[0] = 32'd0;
    m_done[0] = 0;
    @(negedge clock);
    reset[0] = 1'b1;
    #1;
    chk("post_reset_idle", 32'(rx_ready[0]), 32'd0);
    @(negedge clock);
    chk("post_reset_recv", 32'(rx_ready[0]), 32'd1);
    round(0, 32'h0102_0304, 0, -1, 0);

    // Narrow counter with zero latency: count runs 1,2,3,0,1.
    repeat (5) begin
      w = $urandom;
      round(1, w, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
            int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
